// File: rtl/fifo_wr_rr_arb.sv
// fifo_wr_rr_arb: round-robin arbiter sharing one FIFO write port among NREQ requesters.
// A requester is granted for a burst of up to BURST beats. The next search starts at the
// requester after the last owner.
//
// Ports:
//   clk           clock, all state on posedge
//   rst           synchronous active-high reset
//   req_i         per-requester level write request (bit n = requester n)
//   wdata_i       requester n data at [n*DWID +: DWID]
//   fifo_full_i   FIFO full; no write while high
//   gnt_o         one-hot grant, zero when idle
//   fifo_wr_o     FIFO write strobe
//   fifo_wdata_o  owner's data slice
//   owner_o       index of current/last owner
//   busy_o        high while a burst is in progress
module fifo_wr_rr_arb #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned DWID  = 16,
  parameter int unsigned BURST = 4,
  localparam int unsigned IDW  = $clog2(NREQ),
  localparam int unsigned CW   = $clog2(BURST + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_i,
  input  logic [NREQ*DWID-1:0] wdata_i,
  input  logic                 fifo_full_i,
  output logic [NREQ-1:0]      gnt_o,
  output logic                 fifo_wr_o,
  output logic [DWID-1:0]      fifo_wdata_o,
  output logic [IDW-1:0]       owner_o,
  output logic                 busy_o
);

  typedef enum logic {StIdle, StBurst} state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [CW-1:0]  beat_q, beat_d;

  logic            req_own;
  logic [DWID-1:0] wdata_own;
  logic            found;
  logic [IDW-1:0]  sel;
  logic [IDW-1:0]  idx;
  logic [IDW-1:0]  next_ptr;
  logic            xfer;

  // Owner's request bit and data slice.
  always_comb begin
    req_own   = 1'b0;
    wdata_own = '0;
    for (int n = 0; n < int'(NREQ); n++) begin
      if (owner_q == IDW'(n)) begin
        req_own   = req_i[n];
        wdata_own = wdata_i[n*DWID +: DWID];
      end
    end
  end

  // Rotating priority search: ptr, ptr+1, ... wrapping at NREQ-1.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = ptr_q;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (!found && req_i[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
      idx = (idx == IDW'(NREQ - 1)) ? '0 : idx + 1'b1;
    end
  end

  assign next_ptr = (owner_q == IDW'(NREQ - 1)) ? '0 : owner_q + 1'b1;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    beat_d  = beat_q;
    xfer    = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A full FIFO holds off the grant; requests stay pending.
        if (found && !fifo_full_i) begin
          owner_d = sel;
          beat_d  = '0;
          state_d = StBurst;
        end
      end
      StBurst: begin
        xfer = req_own & ~fifo_full_i;
        // Release takes priority over a full stall.
        if (!req_own) begin
          state_d = StIdle;
          ptr_d   = next_ptr;
        end else if (xfer) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == CW'(BURST - 1)) begin
            state_d = StIdle;
            ptr_d   = next_ptr;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      owner_q <= '0;
      ptr_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    gnt_o = '0;
    for (int n = 0; n < int'(NREQ); n++) begin
      gnt_o[n] = (state_q == StBurst) && (owner_q == IDW'(n));
    end
  end

  assign busy_o       = (state_q == StBurst);
  assign fifo_wr_o    = xfer;
  assign fifo_wdata_o = wdata_own;
  assign owner_o      = owner_q;

endmodule

// File: tb/tb_fifo_wr_rr_arb.sv
module tb_fifo_wr_rr_arb;
  localparam int NREQ  = 4;
  localparam int DWID  = 16;
  localparam int BURST = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NREQ-1:0]      req_i = '0;
  logic [NREQ*DWID-1:0] wdata_i = 64'hD3D3_C2C2_B1B1_A0A0;
  logic                 fifo_full_i = 1'b0;
  logic [NREQ-1:0]      gnt_o;
  logic                 fifo_wr_o;
  logic [DWID-1:0]      fifo_wdata_o;
  logic [1:0]           owner_o;
  logic                 busy_o;

  fifo_wr_rr_arb #(.NREQ(NREQ), .DWID(DWID), .BURST(BURST)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_i        (req_i),
    .wdata_i      (wdata_i),
    .fifo_full_i  (fifo_full_i),
    .gnt_o        (gnt_o),
    .fifo_wr_o    (fifo_wr_o),
    .fifo_wdata_o (fifo_wdata_o),
    .owner_o      (owner_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          cyc;
    int          own;
    logic [15:0] data;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Requester data is fixed per requester: A0A0, B1B1, C2C2, D3D3.
  function automatic logic [15:0] dat(input int n);
    logic [63:0] v;
    v = 64'hD3D3_C2C2_B1B1_A0A0;
    return v[n*16 +: 16];
  endfunction

  task automatic push(input int c, input int own);
    exp_t e;
    e.cyc  = c;
    e.own  = own;
    e.data = dat(own);
    q.push_back(e);
  endtask

  task automatic push_run(input int c, input int own, input int n);
    for (int k = 0; k < n; k++) push(c + k, own);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    req_i = '0;
    fifo_full_i = 1'b0;
    step(1);
    rst = 1'b0;
  endtask

  // Monitor: every presented write must match the head of the scoreboard.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc < cyc) begin
      exp_t m;
      m = q.pop_front();
      chk("missed_write_cycle", 32'(cyc), 32'(m.cyc));
    end
    if (fifo_wr_o) begin
      if (q.size() == 0) begin
        chk("unexpected_write", 32'(fifo_wr_o), 32'(0));
      end else begin
        exp_t e;
        logic [31:0] got;
        logic [31:0] want;
        e = q.pop_front();
        got  = {gnt_o, 2'b0, owner_o, fifo_wdata_o, 8'(cyc)};
        want = {4'(1 << e.own), 2'b0, 2'(e.own), e.data, 8'(e.cyc)};
        chk("write{gnt,owner,data,cyc}", got, want);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int c;
    step(2);
    chk("reset_gnt", 32'(gnt_o), 32'(0));
    chk("reset_wr", 32'(fifo_wr_o), 32'(0));
    chk("reset_owner", 32'(owner_o), 32'(0));
    chk("reset_busy", 32'(busy_o), 32'(0));
    chk("reset_wdata_owner0", 32'(fifo_wdata_o), 32'(16'hA0A0));

    // 1: single requester, full burst, one idle cycle, regrant.
    rst = 1'b0;
    c = cyc;
    req_i = 4'b0001;
    push_run(c + 1, 0, 4);
    step(5);
    chk("t1_idle_busy", 32'(busy_o), 32'(0));
    chk("t1_idle_gnt", 32'(gnt_o), 32'(0));
    step(1);
    chk("t1_regrant", 32'(gnt_o), 32'(4'b0001));
    req_i = '0;   // release in first cycle of burst: no write
    step(2);
    chk("t1_release_idle", 32'(busy_o), 32'(0));

    // 2: all requesting, round robin 0,1,2,3,0.
    reset_dut();
    c = cyc;
    req_i = 4'b1111;
    for (int k = 0; k < 5; k++) push_run(c + 1 + 5*k, k % 4, 4);
    step(25);
    req_i = '0;
    step(2);

    // 3: owner 1 stalled by full for 3 cycles after beat 2.
    reset_dut();
    c = cyc;
    req_i = 4'b0010;
    push_run(c + 1, 1, 2);
    push_run(c + 6, 1, 2);
    step(3);
    fifo_full_i = 1'b1;
    step(1);
    chk("t3_stall_gnt", 32'(gnt_o), 32'(4'b0010));
    step(1);
    chk("t3_stall_busy", 32'(busy_o), 32'(1));
    step(1);
    fifo_full_i = 1'b0;
    step(2);
    chk("t3_done_busy", 32'(busy_o), 32'(0));
    req_i = '0;
    step(2);

    // 4: owner 2 releases after 2 beats; requester 3 next.
    reset_dut();
    c = cyc;
    req_i = 4'b0100;
    push_run(c + 1, 2, 2);
    push_run(c + 5, 3, 4);
    step(3);
    req_i = 4'b1000;
    step(1);
    chk("t4_idle_gnt", 32'(gnt_o), 32'(0));
    step(1);
    chk("t4_gnt3", 32'(gnt_o), 32'(4'b1000));
    step(4);
    req_i = '0;
    step(2);

    // 5: reset during beat 3 of owner 3; the beat-3 strobe is still shown combinationally
    // in the reset cycle, nothing after it; next search starts at 0 and picks 1.
    reset_dut();
    c = cyc;
    req_i = 4'b1000;
    push_run(c + 1, 3, 3);
    push_run(c + 5, 1, 4);
    step(3);
    rst = 1'b1;
    req_i = 4'b1010;
    step(1);
    rst = 1'b0;
    chk("t5_after_rst_gnt", 32'(gnt_o), 32'(0));
    chk("t5_after_rst_wr", 32'(fifo_wr_o), 32'(0));
    step(1);
    chk("t5_owner1", 32'(owner_o), 32'(1));
    step(4);
    req_i = '0;
    step(2);

    // 6: full blocks the grant for 5 cycles.
    reset_dut();
    c = cyc;
    req_i = 4'b0100;
    fifo_full_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("t6_blocked_gnt", 32'(gnt_o), 32'(0));
      step(1);
    end
    fifo_full_i = 1'b0;
    chk("t6_still_idle", 32'(busy_o), 32'(0));
    push_run(c + 6, 2, 4);
    step(1);
    chk("t6_gnt2", 32'(gnt_o), 32'(4'b0100));
    step(4);
    req_i = '0;
    step(3);

    chk("scoreboard_drained", 32'(q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
